// File: rtl/score_arb_pkg.sv
// Shared types, default widths and sizing helper for the score arbiter.
package score_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int FW_DEF = 8;
    localparam int SW_DEF = 16;

    // Id width never drops below one bit so N=1 still has a legal port.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/score_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping at N.
module rr_pick
    import score_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = id_w(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any_valid
);

    // Scan from the farthest slot back toward ptr so the nearest hit wins.
    always_comb begin
        int s;
        grant = '0;
        s     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            s = (s >= N) ? s - N : s;
            if (valid[s]) begin
                grant = IDW'(s);
            end else begin
                grant = grant;
            end
        end
        any_valid = |valid;
    end

endmodule

// File: rtl/score_arbiter.sv
// Round-robin arbiter sharing one start/done scoring unit among N requesters.
// Optional scorer watchdog (rsp_err on expiry) enabled by defining SCORE_ARB_TIMEOUT_EN.
module score_arbiter
    import score_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int FW      = FW_DEF,
    parameter  int SW      = SW_DEF,
    parameter  int TIMEOUT = 64,
    localparam int IDW     = id_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*FW-1:0] req_age,
    input  logic [N*FW-1:0] req_iq,
    input  logic [N*FW-1:0] req_shoesize,
    output logic            scr_start,
    output logic [FW-1:0]   scr_age,
    output logic [FW-1:0]   scr_iq,
    output logic [FW-1:0]   scr_shoesize,
    input  logic            scr_done,
    input  logic [SW-1:0]   scr_score,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [SW-1:0]   rsp_score,
    output logic            rsp_err
);

    state_t         state, state_nx;
    logic [IDW-1:0] g, g_nx;
    logic [IDW-1:0] ptr, ptr_nx;
    logic [IDW-1:0] pick;
    logic           any_valid;
    logic [N-1:0]   req_ready_nx;
    logic           scr_start_nx;
    logic [FW-1:0]  age_nx, iq_nx, shoe_nx;
    logic           rsp_valid_nx, rsp_err_nx;
    logic [IDW-1:0] rsp_id_nx;
    logic [SW-1:0]  rsp_score_nx;
`ifdef SCORE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  cnt, cnt_nx;
`endif

    rr_pick #(.N(N)) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (pick),
        .any_valid (any_valid)
    );

    // Next-state and next-output decode; outputs are registered so they follow the state.
    always_comb begin
        state_nx     = state;
        g_nx         = g;
        ptr_nx       = ptr;
        req_ready_nx = '0;
        scr_start_nx = 1'b0;
        age_nx       = scr_age;
        iq_nx        = scr_iq;
        shoe_nx      = scr_shoesize;
        rsp_valid_nx = rsp_valid;
        rsp_id_nx    = rsp_id;
        rsp_score_nx = rsp_score;
        rsp_err_nx   = rsp_err;
`ifdef SCORE_ARB_TIMEOUT_EN
        cnt_nx       = cnt;
`endif
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nx           = ISSUE;
                    g_nx               = pick;
                    req_ready_nx[pick] = 1'b1;
                    scr_start_nx       = 1'b1;
                    age_nx             = req_age[int'(pick)*FW +: FW];
                    iq_nx              = req_iq[int'(pick)*FW +: FW];
                    shoe_nx            = req_shoesize[int'(pick)*FW +: FW];
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                // Explicit compare instead of a modulo: N need not be a power of two.
                ptr_nx   = (g == IDW'(N - 1)) ? '0 : g + IDW'(1);
`ifdef SCORE_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT: begin
                if (scr_done) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_id_nx    = g;
                    rsp_score_nx = scr_score;
`ifdef SCORE_ARB_TIMEOUT_EN
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_id_nx    = g;
                    rsp_score_nx = '0;
                    rsp_err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
`else
                end else begin
                    state_nx = WAIT;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                    rsp_err_nx   = 1'b0;
                end else begin
                    state_nx = RESP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; rst abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            g            <= '0;
            ptr          <= '0;
            req_ready    <= '0;
            scr_start    <= 1'b0;
            scr_age      <= '0;
            scr_iq       <= '0;
            scr_shoesize <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_score    <= '0;
            rsp_err      <= 1'b0;
`ifdef SCORE_ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            state        <= state_nx;
            g            <= g_nx;
            ptr          <= ptr_nx;
            req_ready    <= req_ready_nx;
            scr_start    <= scr_start_nx;
            scr_age      <= age_nx;
            scr_iq       <= iq_nx;
            scr_shoesize <= shoe_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_id       <= rsp_id_nx;
            rsp_score    <= rsp_score_nx;
            rsp_err      <= rsp_err_nx;
`ifdef SCORE_ARB_TIMEOUT_EN
            cnt          <= cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: round-robin/latency reference model, scorer model, random traffic.
module tb_score_arbiter;

    localparam int N   = 4;
    localparam int FW  = 8;
    localparam int SW  = 16;
    localparam int TMO = 8;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_age, req_iq, req_shoesize;
    logic            scr_start;
    logic [FW-1:0]   scr_age, scr_iq, scr_shoesize;
    logic            scr_done = 1'b0;
    logic [SW-1:0]   scr_score = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [IDW-1:0]  rsp_id;
    logic [SW-1:0]   rsp_score;
    logic            rsp_err;

    logic [FW-1:0] age_a[N], iq_a[N], shoe_a[N];

    typedef struct {
        int id;
        int score;
        int err;
        int lat;
        int t_issue;
    } exp_t;
    typedef struct {
        int id;
        logic [FW-1:0] a;
        logic [FW-1:0] q;
        logic [FW-1:0] s;
    } post_t;

    exp_t  exp_q[$];
    post_t post_q[$];

    int vectors = 0, miscompares = 0;
    int cyc = 0, m_ptr = 0, last_issue = -1, sc_cnt = 0;
    int lat_lo = 1, lat_hi = 4, spur_req = 0, spur_done = 0;
    bit mute = 1'b0, auto_refill = 1'b0, cont_check = 1'b0, rand_mode = 1'b0, first_seen = 1'b0;
    logic [SW-1:0] sc_val = '0;
    logic [N-1:0]  prev_valid = '0;
    logic          prev_rst = 1'b0;

    score_arbiter #(.N(N), .FW(FW), .SW(SW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_age      (req_age),
        .req_iq       (req_iq),
        .req_shoesize (req_shoesize),
        .scr_start    (scr_start),
        .scr_age      (scr_age),
        .scr_iq       (scr_iq),
        .scr_shoesize (scr_shoesize),
        .scr_done     (scr_done),
        .scr_score    (scr_score),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_score    (rsp_score),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_age      = '0;
        req_iq       = '0;
        req_shoesize = '0;
        for (int i = 0; i < N; i++) begin
            req_age[i*FW +: FW]      = age_a[i];
            req_iq[i*FW +: FW]       = iq_a[i];
            req_shoesize[i*FW +: FW] = shoe_a[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first pending requester scanning upward from p, wrapping.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post(input int id, input logic [FW-1:0] a, input logic [FW-1:0] q, input logic [FW-1:0] s);
        post_t p;
        p.id = id; p.a = a; p.q = q; p.s = s;
        post_q.push_back(p);
    endtask

    task automatic post_rand(input int id);
        post(id, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || exp_q.size() != 0 || post_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_done", 64'({req_valid != '0, exp_q.size() != 0}), 64'd0);
    endtask

    // Monitor, scoreboard, scorer model and requester sources, all sampled on the falling edge.
    initial begin : monitor
        exp_t  e;
        post_t p;
        int    g, lat;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (prev_rst) begin
                    chk("reset_ctrl", 64'({req_ready, scr_start, rsp_valid, rsp_err}), 64'd0);
                    chk("reset_data", 64'({scr_age, scr_iq, scr_shoesize, rsp_id, rsp_score}), 64'd0);
                end
                exp_q.delete();
                m_ptr = 0; sc_cnt = 0; scr_done = 1'b0; last_issue = -1; first_seen = 1'b0;
            end else begin
                scr_done = 1'b0;
                if (sc_cnt > 0) begin
                    sc_cnt--;
                    if (sc_cnt == 0) begin
                        scr_done  = 1'b1;
                        scr_score = sc_val;
                    end
                end
                if (spur_req != spur_done) begin
                    spur_done = spur_req;
                    scr_done  = 1'b1;
                    scr_score = 16'd999;
                end
                if (!cont_check) last_issue = -1;
                if (req_ready != '0 || scr_start) begin
                    g = model_pick(prev_valid, m_ptr);
                    chk("one_outstanding", 64'(exp_q.size()), 64'd0);
                    if (g < 0) begin
                        chk("grant_without_request", 64'(req_ready), 64'd0);
                    end else begin
                        chk("grant", 64'(req_ready), 64'(1 << g));
                        chk("scr_start", 64'(scr_start), 64'd1);
                        chk("scr_fields", 64'({scr_age, scr_iq, scr_shoesize}), 64'({age_a[g], iq_a[g], shoe_a[g]}));
                        if (cont_check && last_issue >= 0) chk("issue_period", 64'(cyc - last_issue), 64'd4);
                        last_issue = cyc;
                        m_ptr = (g + 1) % N;
                        lat = int'($urandom_range(lat_hi, lat_lo));
                        e.id      = g;
                        e.err     = mute ? 1 : 0;
                        e.score   = mute ? 0 : (int'(age_a[g]) + int'(iq_a[g]) + int'(shoe_a[g])) % 65536;
                        e.lat     = mute ? TMO + 1 : lat + 1;
                        e.t_issue = cyc;
                        exp_q.push_back(e);
                        if (!mute) begin
                            sc_cnt = lat;
                            sc_val = SW'(scr_age) + SW'(scr_iq) + SW'(scr_shoesize);
                        end
                        if (auto_refill) begin
                            age_a[g] = 8'($urandom); iq_a[g] = 8'($urandom); shoe_a[g] = 8'($urandom);
                        end else begin
                            req_valid[g] = 1'b0;
                        end
                    end
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q[0];
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_score", 64'(rsp_score), 64'(e.score));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        if (!first_seen) begin
                            chk("rsp_latency", 64'(cyc - e.t_issue), 64'(e.lat));
                            first_seen = 1'b1;
                        end
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            first_seen = 1'b0;
                        end
                    end
                end
                if (rand_mode) begin
                    for (int i = 0; i < N; i++) begin
                        if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
                            req_valid[i] = 1'b1;
                            age_a[i] = 8'($urandom); iq_a[i] = 8'($urandom); shoe_a[i] = 8'($urandom);
                        end
                    end
                end
            end
            while (post_q.size() > 0) begin
                p = post_q.pop_front();
                req_valid[p.id] = 1'b1;
                age_a[p.id] = p.a; iq_a[p.id] = p.q; shoe_a[p.id] = p.s;
            end
            prev_rst   = rst;
            prev_valid = req_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin : main
        int n;
        for (int i = 0; i < N; i++) begin
            age_a[i] = '0; iq_a[i] = '0; shoe_a[i] = '0;
        end
        tick(4);
        rst = 1'b0;
        tick(2);
        spur_req++;                       // stray done while idle must be ignored
        tick(4);

        // Single request from requester 2, scorer latency 2.
        lat_lo = 2; lat_hi = 2; rsp_ready = 1'b1;
        post(2, 8'd30, 8'd110, 8'd42);
        drain(60);

        // All requesters continuously valid, latency 1: one grant every 4 cycles.
        lat_lo = 1; lat_hi = 1; cont_check = 1'b1; auto_refill = 1'b1;
        for (int i = 0; i < N; i++) post_rand(i);
        tick(24);
        cont_check = 1'b0; auto_refill = 1'b0;
        drain(100);

        // Response backpressure for 10 cycles with another request pending.
        lat_lo = 1; lat_hi = 4; rsp_ready = 1'b0;
        post_rand(0); post_rand(1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        tick(10);
        rsp_ready = 1'b1;
        drain(60);

        // Sparse: requester 1 alone moves ptr to 2, then 1 and 3 together.
        post_rand(1);
        drain(40);
        post_rand(1); post_rand(3);
        drain(60);

        // Reset while the scorer is busy, then all four request.
        lat_lo = 4; lat_hi = 4;
        post_rand(2);
        n = 0;
        while (exp_q.size() == 0 && n < 20) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        tick(3);
        for (int i = 0; i < N; i++) post_rand(i);
        tick(1);
        rst = 1'b0;
        lat_lo = 1; lat_hi = 4;
        drain(100);

`ifdef SCORE_ARB_TIMEOUT_EN
        // Silent scorer: watchdog response, then normal service resumes.
        mute = 1'b1;
        post_rand(1);
        drain(60);
        mute = 1'b0;
        post_rand(2);
        drain(60);
`endif

        // Random traffic with random response backpressure.
        rand_mode = 1'b1;
        repeat (400) begin
            rsp_ready = ($urandom_range(3, 0) != 0);
            tick(1);
        end
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        drain(200);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
